// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one shift step per clock.
// Converts the multiplier product into packed BCD digits behind a start/busy/done handshake.
module product_bcd_converter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned STEP_W = BCD_W + WIDTH;

    // Elaboration-time guard: enough digits to hold the largest binary value.
    function automatic bit digits_sufficient(input int unsigned w, input int unsigned d);
        longint unsigned max_bin;
        longint unsigned cap;
        max_bin = (64'd1 << w) - 64'd1;
        cap     = 64'd1;
        for (int unsigned i = 0; i < d; i++) begin
            cap = cap * 64'd10;
        end
        return cap > max_bin;
    endfunction

    if (!digits_sufficient(WIDTH, DIGITS)) begin : g_bad_params
        $error("product_bcd_converter: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    shreg_q;
    logic [WIDTH-1:0]    shreg_d;
    logic [BCD_W-1:0]    scratch_q;
    logic [BCD_W-1:0]    scratch_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                busy_d;
    logic                done_d;
    logic [BCD_W-1:0]    bcd_d;
    logic [BCD_W-1:0]    adj;
    logic [STEP_W-1:0]   step;

    // Add-3 correction per digit (no carry between digits), then one left shift.
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = 4'(scratch_q[4*i +: 4] + 4'd3);
            end else begin
                adj[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
        step = {adj, shreg_q} << 1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_out;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy_d                = 1'b1;
                {scratch_d, shreg_d}  = step;
                cnt_d                 = cnt_q - CNT_W'(1);
                // Final shift: publish result so done and bcd_out appear together.
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = step[WIDTH +: BCD_W];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            bcd_out   <= bcd_d;
        end
    end

endmodule
